fetch_decode_execute: RTL and testbench

// - First three stages (IF, ID, EX) of the 5-stage 32-bit MIPS pipeline: fetch, decode/register read, execute.
// - Holds the PC, instruction ROM, register file and the IF/ID, ID/EX and EX/MEM pipeline registers.
// - The EX/MEM outputs feed the MEMORY stage. PCSrc comes back from MEMORY; regwrite, rd and data come back from WB.

---
 rtl/fetch_decode_execute_pkg.sv | 105 ++++++++++
 rtl/fetch_decode_execute_gpr_file.sv | 42 ++++
 rtl/fetch_decode_execute.sv | 166 ++++++++++++++++
 tb/tb_fetch_decode_execute.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_execute_pkg.sv
// Shared definitions for the IF/ID/EX front end of the 5-stage MIPS pipeline:
// opcode/funct encodings, control bundles and the decode helpers.
package fetch_decode_execute_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_ZERO
  } alu_sel_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctl_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_ctl_t;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
  } ex_ctl_t;

  typedef struct packed {
    wb_ctl_t wb;
    m_ctl_t  m;
    ex_ctl_t ex;
  } ctl_t;

  // Unrecognised opcodes fall through as an all-zero bundle, i.e. a bubble.
  function automatic ctl_t decode_ctl(input logic [5:0] opcode);
    ctl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.ex.regdst   = 1'b1;
        c.ex.aluop    = ALUOP_FUNCT;
        c.wb.regwrite = 1'b1;
      end
      OP_LW: begin
        c.ex.alusrc   = 1'b1;
        c.ex.aluop    = ALUOP_ADD;
        c.wb.regwrite = 1'b1;
        c.wb.memtoreg = 1'b1;
        c.m.memread   = 1'b1;
      end
      OP_SW: begin
        c.ex.alusrc = 1'b1;
        c.ex.aluop  = ALUOP_ADD;
        c.m.memwrite = 1'b1;
      end
      OP_BEQ: begin
        c.ex.aluop = ALUOP_SUB;
        c.m.branch = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic alu_sel_t alu_select(input logic [1:0] aluop, input logic [5:0] funct);
    alu_sel_t sel;
    if (aluop == ALUOP_ADD) begin
      sel = ALU_ADD;
    end else if (aluop == ALUOP_SUB) begin
      sel = ALU_SUB;
    end else begin
      case (funct)
        FUNCT_ADD: sel = ALU_ADD;
        FUNCT_SUB: sel = ALU_SUB;
        FUNCT_AND: sel = ALU_AND;
        FUNCT_OR:  sel = ALU_OR;
        FUNCT_SLT: sel = ALU_SLT;
        default:   sel = ALU_ZERO;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/fetch_decode_execute_gpr_file.sv
// 32x32 general-purpose register file: two combinational read ports, one
// write port, $0 hardwired to zero, write-through on same-cycle read.
module gpr_file
  import fetch_decode_execute_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] wa,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [32];
  logic              wr_en;

  assign wr_en = we && (wa != '0);

  // NOTE: this array is architectural state that must read 0 after reset,
  // so it is cleared by rst rather than left to power-up contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Bypass lets ID see a value being written back in the same cycle.
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (wr_en && wa == ra1) rd1 = wd;
    if (wr_en && wa == ra2) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/fetch_decode_execute.sv
// IF, ID and EX stages of the 5-stage MIPS pipeline, ending in the EX/MEM
// register that feeds the MEMORY stage. No forwarding, stalls or flushes.
module fetch_decode_execute
  import fetch_decode_execute_pkg::*;
#(
  parameter int    IMEM_DEPTH = 128,
  parameter string IMEM_INIT  = "instr.mem"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_PCSrc,
  input  logic [REG_AW-1:0] MEM_WB_rd,
  input  logic              MEM_WB_regwrite,
  input  logic [DATA_W-1:0] WB_mux5_writedata,
  output logic [1:0]        wb_ctlout,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic [DATA_W-1:0] EX_MEM_NPC,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [REG_AW-1:0] five_bit_muxout
);

  // ---------------- IF ----------------
  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0] pc, npc, instr;
  logic [6:0]        imem_addr;

  // ROM words not explicitly loaded read 0.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
  end

  assign imem_addr = pc[6:0];
  assign npc       = pc + 32'd1;
  assign instr     = (int'(imem_addr) < IMEM_DEPTH) ? imem[imem_addr] : '0;

  logic [DATA_W-1:0] if_id_instr, if_id_npc, ex_mem_target;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      if_id_instr <= '0;
      if_id_npc   <= '0;
    end else begin
      pc          <= EX_MEM_PCSrc ? ex_mem_target : npc;
      if_id_instr <= instr;
      if_id_npc   <= npc;
    end
  end

  // ---------------- ID ----------------
  ctl_t              id_ctl;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_sext;

  assign id_ctl  = decode_ctl(if_id_instr[31:26]);
  assign id_sext = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

  gpr_file u_gpr_file (
    .clk (clk),
    .rst (rst),
    .ra1 (if_id_instr[25:21]),
    .ra2 (if_id_instr[20:16]),
    .wa  (MEM_WB_rd),
    .we  (MEM_WB_regwrite),
    .wd  (WB_mux5_writedata),
    .rd1 (id_rdata1),
    .rd2 (id_rdata2)
  );

  wb_ctl_t           id_ex_wb;
  m_ctl_t            id_ex_m;
  ex_ctl_t           id_ex_ex;
  logic [DATA_W-1:0] id_ex_npc, id_ex_rdata1, id_ex_rdata2, id_ex_sext;
  logic [REG_AW-1:0] id_ex_rt, id_ex_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_wb     <= '0;
      id_ex_m      <= '0;
      id_ex_ex     <= '0;
      id_ex_npc    <= '0;
      id_ex_rdata1 <= '0;
      id_ex_rdata2 <= '0;
      id_ex_sext   <= '0;
      id_ex_rt     <= '0;
      id_ex_rd     <= '0;
    end else begin
      id_ex_wb     <= id_ctl.wb;
      id_ex_m      <= id_ctl.m;
      id_ex_ex     <= id_ctl.ex;
      id_ex_npc    <= if_id_npc;
      id_ex_rdata1 <= id_rdata1;
      id_ex_rdata2 <= id_rdata2;
      id_ex_sext   <= id_sext;
      id_ex_rt     <= if_id_instr[20:16];
      id_ex_rd     <= if_id_instr[15:11];
    end
  end

  // ---------------- EX ----------------
  alu_sel_t          alu_sel;
  logic [DATA_W-1:0] alu_b, ex_result, ex_target;
  logic [REG_AW-1:0] ex_dest;

  // The funct field rides along in the low bits of the sign-extended immediate.
  assign alu_sel   = alu_select(id_ex_ex.aluop, id_ex_sext[5:0]);
  assign alu_b     = id_ex_ex.alusrc ? id_ex_sext : id_ex_rdata2;
  assign ex_target = id_ex_npc + id_ex_sext;
  assign ex_dest   = id_ex_ex.regdst ? id_ex_rd : id_ex_rt;

  // NOTE: assigning a default before the case keeps every path driven, so
  // no latch is inferred for ex_result.
  always_comb begin
    ex_result = '0;
    case (alu_sel)
      ALU_ADD: ex_result = id_ex_rdata1 + alu_b;
      ALU_SUB: ex_result = id_ex_rdata1 - alu_b;
      ALU_AND: ex_result = id_ex_rdata1 & alu_b;
      ALU_OR:  ex_result = id_ex_rdata1 | alu_b;
      ALU_SLT: ex_result = {{(DATA_W-1){1'b0}}, $signed(id_ex_rdata1) < $signed(alu_b)};
      default: ex_result = '0;
    endcase
  end

  wb_ctl_t           ex_mem_wb;
  m_ctl_t            ex_mem_m;
  logic              ex_mem_zero;
  logic [DATA_W-1:0] ex_mem_result, ex_mem_rdata2;
  logic [REG_AW-1:0] ex_mem_dest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_wb     <= '0;
      ex_mem_m      <= '0;
      ex_mem_target <= '0;
      ex_mem_zero   <= 1'b0;
      ex_mem_result <= '0;
      ex_mem_rdata2 <= '0;
      ex_mem_dest   <= '0;
    end else begin
      ex_mem_wb     <= id_ex_wb;
      ex_mem_m      <= id_ex_m;
      ex_mem_target <= ex_target;
      ex_mem_zero   <= (ex_result == '0);
      ex_mem_result <= ex_result;
      ex_mem_rdata2 <= id_ex_rdata2;
      ex_mem_dest   <= ex_dest;
    end
  end

  assign wb_ctlout       = ex_mem_wb;
  assign branch          = ex_mem_m.branch;
  assign memread         = ex_mem_m.memread;
  assign memwrite        = ex_mem_m.memwrite;
  assign EX_MEM_NPC      = ex_mem_target;
  assign zero            = ex_mem_zero;
  assign alu_result      = ex_mem_result;
  assign rdata2out       = ex_mem_rdata2;
  assign five_bit_muxout = ex_mem_dest;

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed bench for fetch_decode_execute: programs are poked into the ROM,
// operands arrive through the writeback port, EX/MEM outputs are compared.
module tb_fetch_decode_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_MEM_PCSrc;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_regwrite;
  logic [31:0] WB_mux5_writedata;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
  logic [4:0]  five_bit_muxout;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  fetch_decode_execute #(.IMEM_DEPTH(128), .IMEM_INIT("")) dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MEM_PCSrc      (EX_MEM_PCSrc),
    .MEM_WB_rd         (MEM_WB_rd),
    .MEM_WB_regwrite   (MEM_WB_regwrite),
    .WB_mux5_writedata (WB_mux5_writedata),
    .wb_ctlout         (wb_ctlout),
    .branch            (branch),
    .memread           (memread),
    .memwrite          (memwrite),
    .EX_MEM_NPC        (EX_MEM_NPC),
    .zero              (zero),
    .alu_result        (alu_result),
    .rdata2out         (rdata2out),
    .five_bit_muxout   (five_bit_muxout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) tick();
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic [31:0] data, input logic we);
    MEM_WB_rd         = rd;
    WB_mux5_writedata = data;
    MEM_WB_regwrite   = we;
  endtask

  task automatic hold_reset();
    rst          = 1'b1;
    EX_MEM_PCSrc = 1'b0;
    set_wb(5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 128; i++) dut.imem[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst      = 1'b0;
    edge_cnt = 0;
  endtask

  task automatic test_reset();
    hold_reset();
    for (int i = 0; i < 128; i++) dut.imem[i] = 32'h1000_0000; // beq $0,$0,0
    release_reset();
    wait_edge(4);
    checks++; if (EX_MEM_NPC !== 32'd2) begin errors++; $display("FAIL pre_reset_npc: got %h want %h", EX_MEM_NPC, 32'd2); end
    checks++; if (branch !== 1'b1) begin errors++; $display("FAIL pre_reset_branch: got %b want 1", branch); end
    #2 rst = 1'b1;
    #1;
    checks++; if (wb_ctlout !== 2'b00) begin errors++; $display("FAIL rst_wb: got %b want 00", wb_ctlout); end
    checks++; if (branch !== 1'b0) begin errors++; $display("FAIL rst_branch: got %b want 0", branch); end
    checks++; if (memread !== 1'b0) begin errors++; $display("FAIL rst_memread: got %b want 0", memread); end
    checks++; if (memwrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite: got %b want 0", memwrite); end
    checks++; if (EX_MEM_NPC !== 32'd0) begin errors++; $display("FAIL rst_npc: got %h want 0", EX_MEM_NPC); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rst_zero: got %b want 0", zero); end
    checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL rst_result: got %h want 0", alu_result); end
    checks++; if (rdata2out !== 32'd0) begin errors++; $display("FAIL rst_rdata2: got %h want 0", rdata2out); end
    checks++; if (five_bit_muxout !== 5'd0) begin errors++; $display("FAIL rst_dest: got %0d want 0", five_bit_muxout); end
    release_reset();
    // Each beq $0,$0,0 carries PC+1 as its target, exposing the PC sequence.
    for (int k = 0; k < 3; k++) begin
      wait_edge(3 + k);
      checks++; if (EX_MEM_NPC !== 32'(k + 1)) begin errors++; $display("FAIL pc_seq_%0d: got %h want %h", k, EX_MEM_NPC, 32'(k + 1)); end
    end
  endtask

  task automatic test_rtype_add();
    hold_reset();
    dut.imem[0] = 32'h0022_1820; // add $3,$1,$2
    release_reset();
    set_wb(5'd1, 32'd5, 1'b1);
    tick();
    set_wb(5'd2, 32'd7, 1'b1);
    tick();
    set_wb(5'd0, 32'd0, 1'b0);
    tick();
    checks++; if (alu_result !== 32'd12) begin errors++; $display("FAIL add_result: got %h want %h", alu_result, 32'd12); end
    checks++; if (five_bit_muxout !== 5'd3) begin errors++; $display("FAIL add_dest: got %0d want 3", five_bit_muxout); end
    checks++; if (wb_ctlout !== 2'b10) begin errors++; $display("FAIL add_wb: got %b want 10", wb_ctlout); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b want 0", zero); end
    checks++; if ({branch, memread, memwrite} !== 3'b000) begin errors++; $display("FAIL add_mctl: got %b want 000", {branch, memread, memwrite}); end
    checks++; if (rdata2out !== 32'd7) begin errors++; $display("FAIL add_rdata2: got %h want 7", rdata2out); end
    checks++; if (EX_MEM_NPC !== 32'h1821) begin errors++; $display("FAIL add_target: got %h want 00001821", EX_MEM_NPC); end
  endtask

  task automatic test_lw_sw();
    hold_reset();
    dut.imem[4] = 32'h8C24_FFFC; // lw $4,-4($1)
    dut.imem[5] = 32'hAC02_0008; // sw $2,8($0)
    release_reset();
    set_wb(5'd1, 32'd5, 1'b1);
    tick();
    set_wb(5'd2, 32'd7, 1'b1);
    tick();
    set_wb(5'd0, 32'd0, 1'b0);
    wait_edge(7);
    checks++; if (alu_result !== 32'd1) begin errors++; $display("FAIL lw_result: got %h want 1", alu_result); end
    checks++; if ({memread, memwrite} !== 2'b10) begin errors++; $display("FAIL lw_mem: got %b want 10", {memread, memwrite}); end
    checks++; if (wb_ctlout !== 2'b11) begin errors++; $display("FAIL lw_wb: got %b want 11", wb_ctlout); end
    checks++; if (five_bit_muxout !== 5'd4) begin errors++; $display("FAIL lw_dest: got %0d want 4", five_bit_muxout); end
    checks++; if (EX_MEM_NPC !== 32'd1) begin errors++; $display("FAIL lw_target: got %h want 1", EX_MEM_NPC); end
    wait_edge(8);
    checks++; if (alu_result !== 32'd8) begin errors++; $display("FAIL sw_result: got %h want 8", alu_result); end
    checks++; if ({memread, memwrite} !== 2'b01) begin errors++; $display("FAIL sw_mem: got %b want 01", {memread, memwrite}); end
    checks++; if (rdata2out !== 32'd7) begin errors++; $display("FAIL sw_rdata2: got %h want 7", rdata2out); end
    checks++; if (wb_ctlout !== 2'b00) begin errors++; $display("FAIL sw_wb: got %b want 00", wb_ctlout); end
  endtask

  task automatic test_beq();
    hold_reset();
    dut.imem[4] = 32'h1021_0003; // beq $1,$1,+3
    dut.imem[8] = 32'h0021_1820; // add $3,$1,$1
    release_reset();
    set_wb(5'd1, 32'd5, 1'b1);
    tick();
    set_wb(5'd0, 32'd0, 1'b0);
    wait_edge(7);
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL beq_zero: got %b want 1", zero); end
    checks++; if (branch !== 1'b1) begin errors++; $display("FAIL beq_branch: got %b want 1", branch); end
    checks++; if (EX_MEM_NPC !== 32'd8) begin errors++; $display("FAIL beq_target: got %h want 8", EX_MEM_NPC); end
    checks++; if (wb_ctlout !== 2'b00) begin errors++; $display("FAIL beq_wb: got %b want 00", wb_ctlout); end
    EX_MEM_PCSrc = 1'b1;
    tick();
    EX_MEM_PCSrc = 1'b0;
    wait_edge(11);
    checks++; if (alu_result !== 32'd10) begin errors++; $display("FAIL beq_fetch8_result: got %h want a", alu_result); end
    checks++; if (five_bit_muxout !== 5'd3) begin errors++; $display("FAIL beq_fetch8_dest: got %0d want 3", five_bit_muxout); end

    // Far target: the redirect must be visible, and the slots behind it still run.
    hold_reset();
    dut.imem[4]  = 32'h1021_0014; // beq $1,$1,+20
    dut.imem[7]  = 32'h0021_4025; // or  $8,$1,$1
    dut.imem[8]  = 32'h0021_4825; // or  $9,$1,$1 (skipped)
    dut.imem[25] = 32'h0021_1820; // add $3,$1,$1
    release_reset();
    set_wb(5'd1, 32'd5, 1'b1);
    tick();
    set_wb(5'd0, 32'd0, 1'b0);
    wait_edge(7);
    checks++; if (EX_MEM_NPC !== 32'd25) begin errors++; $display("FAIL far_target: got %h want 19", EX_MEM_NPC); end
    EX_MEM_PCSrc = 1'b1;
    tick();
    EX_MEM_PCSrc = 1'b0;
    wait_edge(10);
    checks++; if ({five_bit_muxout, alu_result} !== {5'd8, 32'd5}) begin errors++; $display("FAIL no_flush: got dest %0d res %h want dest 8 res 5", five_bit_muxout, alu_result); end
    wait_edge(11);
    checks++; if ({five_bit_muxout, alu_result} !== {5'd3, 32'd10}) begin errors++; $display("FAIL redirect: got dest %0d res %h want dest 3 res a", five_bit_muxout, alu_result); end
  endtask

  task automatic test_writeback();
    hold_reset();
    dut.imem[4] = 32'h0000_1820; // add $3,$0,$0
    release_reset();
    set_wb(5'd0, 32'h0000_FFFF, 1'b1);
    wait_edge(7);
    checks++; if (alu_result !== 32'd0) begin errors++; $display("FAIL r0_result: got %h want 0", alu_result); end
    checks++; if (rdata2out !== 32'd0) begin errors++; $display("FAIL r0_rdata2: got %h want 0", rdata2out); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL r0_zero: got %b want 1", zero); end

    hold_reset();
    dut.imem[4] = 32'h0021_1820; // add $3,$1,$1
    release_reset();
    wait_edge(5);
    set_wb(5'd1, 32'h0000_1234, 1'b1);
    tick();
    set_wb(5'd0, 32'd0, 1'b0);
    wait_edge(7);
    checks++; if (alu_result !== 32'h2468) begin errors++; $display("FAIL bypass_result: got %h want 00002468", alu_result); end
    checks++; if (rdata2out !== 32'h1234) begin errors++; $display("FAIL bypass_rdata2: got %h want 00001234", rdata2out); end
  endtask

  task automatic test_alu_edges();
    hold_reset();
    dut.imem[4]  = 32'h0022_282A; // slt $5,$1,$2
    dut.imem[5]  = 32'h0063_3022; // sub $6,$3,$3
    dut.imem[6]  = 32'h0082_3820; // add $7,$4,$2
    dut.imem[7]  = 32'hFC22_1820; // opcode 0x3F
    dut.imem[8]  = 32'h0062_4024; // and $8,$3,$2
    dut.imem[9]  = 32'h0043_4825; // or  $9,$2,$3
    dut.imem[10] = 32'h0063_5021; // funct 0x21
    release_reset();
    set_wb(5'd1, 32'hFFFF_FFFF, 1'b1);
    tick();
    set_wb(5'd2, 32'd1, 1'b1);
    tick();
    set_wb(5'd3, 32'd3, 1'b1);
    tick();
    set_wb(5'd4, 32'h7FFF_FFFF, 1'b1);
    tick();
    set_wb(5'd0, 32'd0, 1'b0);
    wait_edge(7);
    checks++; if (alu_result !== 32'd1) begin errors++; $display("FAIL slt_result: got %h want 1", alu_result); end
    checks++; if (five_bit_muxout !== 5'd5) begin errors++; $display("FAIL slt_dest: got %0d want 5", five_bit_muxout); end
    wait_edge(8);
    checks++; if ({zero, alu_result} !== {1'b1, 32'd0}) begin errors++; $display("FAIL sub_zero: got z%b %h want z1 0", zero, alu_result); end
    wait_edge(9);
    checks++; if ({zero, alu_result} !== {1'b0, 32'h8000_0000}) begin errors++; $display("FAIL add_wrap: got z%b %h want z0 80000000", zero, alu_result); end
    wait_edge(10);
    checks++; if ({wb_ctlout, branch, memread, memwrite} !== 5'b0) begin errors++; $display("FAIL bad_opcode_ctl: got %b want 00000", {wb_ctlout, branch, memread, memwrite}); end
    wait_edge(11);
    checks++; if (alu_result !== 32'd1) begin errors++; $display("FAIL and_result: got %h want 1", alu_result); end
    wait_edge(12);
    checks++; if (alu_result !== 32'd3) begin errors++; $display("FAIL or_result: got %h want 3", alu_result); end
    wait_edge(13);
    checks++; if ({zero, alu_result} !== {1'b1, 32'd0}) begin errors++; $display("FAIL bad_funct: got z%b %h want z1 0", zero, alu_result); end
    checks++; if (wb_ctlout !== 2'b10) begin errors++; $display("FAIL bad_funct_wb: got %b want 10", wb_ctlout); end
  endtask

  initial begin
    rst               = 1'b1;
    EX_MEM_PCSrc      = 1'b0;
    MEM_WB_rd         = 5'd0;
    MEM_WB_regwrite   = 1'b0;
    WB_mux5_writedata = 32'd0;
    #2;
    test_reset();
    test_rtype_add();
    test_lw_sw();
    test_beq();
    test_writeback();
    test_alu_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
